// File: rtl/hazard_scoreboard_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : hazard_pkg
//  Purpose  : Shared types for the hazard scoreboard. It holds the operand
//             forward-select encoding and the multi-cycle FSM state encoding.
//  Revision : 1.0 - initial release
// ============================================================================
package hazard_pkg;

    // Operand source select for an E-stage operand.
    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,   // register file value
        FWD_WB  = 2'b01,   // forwarded from writeback
        FWD_MEM = 2'b10    // forwarded from memory stage
    } fwd_sel_e;

    // Multi-cycle unit tracking FSM.
    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } fsm_state_e;

endpackage : hazard_pkg
`default_nettype wire

// File: rtl/hazard_scoreboard_fwd_sel.sv
`default_nettype none
// ============================================================================
//  Module   : fwd_sel
//  Purpose  : Forward-select for a single E-stage source operand. The memory
//             stage has priority over writeback because it holds the younger
//             result.
//  Ports    : rs_i          - E-stage source register index
//             rd_m_i        - M-stage destination index
//             regwrite_m_i  - M-stage write enable
//             rd_w_i        - W-stage destination index
//             regwrite_w_i  - W-stage write enable
//             sel_o         - operand source select (FWD_RF/FWD_WB/FWD_MEM)
//  Revision : 1.0 - initial release
// ============================================================================
module fwd_sel
    import hazard_pkg::*;
#(
    parameter int AW       = 5,
    parameter int ZERO_REG = 1
) (
    input  logic [AW-1:0] rs_i,
    input  logic [AW-1:0] rd_m_i,
    input  logic          regwrite_m_i,
    input  logic [AW-1:0] rd_w_i,
    input  logic          regwrite_w_i,
    output fwd_sel_e      sel_o
);

    logic rs_live;
    logic match_m;
    logic match_w;

    // With a hardwired zero register, index 0 never carries a pending value.
    assign rs_live = (ZERO_REG == 0) || (rs_i != '0);
    assign match_m = rs_live && regwrite_m_i && (rd_m_i == rs_i);
    assign match_w = rs_live && regwrite_w_i && (rd_w_i == rs_i);

    always_comb begin
        sel_o = FWD_RF;
        if (match_m) begin
            sel_o = FWD_MEM;
        end else if (match_w) begin
            sel_o = FWD_WB;
        end
    end

endmodule : fwd_sel
`default_nettype wire

// File: rtl/hazard_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module   : hazard_scoreboard
//  Purpose  : Pipeline hazard unit: operand forwarding, load-use stall,
//             branch flushes and tracking of a multi-cycle (FPU-style) unit
//             that holds the E stage until its result is ready or a latency
//             timeout fires.
//  Ports    : clk, reset                 - clock, sync active-high reset
//             Rs1D/Rs2D                  - decode-stage source indices
//             Rs1E/Rs2E/RdE              - execute-stage sources/destination
//             RdM/RdW                    - M/W destinations
//             RegWriteE/M/W              - destination write enables
//             ResultSrcE0                - E instruction is a load
//             PCJmpE                     - taken branch/jump resolved in E
//             FPUStartE/FPUDoneE         - multi-cycle op present / result valid
//             ForwardAE/ForwardBE        - operand source selects
//             StallF/D/E, FlushD/E/M     - pipeline control
//             FPUBusy                    - FSM is in BUSY
//             FPUTimeout                 - sticky multi-cycle timeout flag
//  Revision : 1.0 - initial release
// ============================================================================
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int NREG     = 32,
    parameter int AW       = $clog2(NREG),
    parameter int MAXLAT   = 15,          // must be >= 1
    parameter int ZERO_REG = 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [AW-1:0] Rs1D,
    input  logic [AW-1:0] Rs2D,
    input  logic [AW-1:0] Rs1E,
    input  logic [AW-1:0] Rs2E,
    input  logic [AW-1:0] RdE,
    input  logic [AW-1:0] RdM,
    input  logic [AW-1:0] RdW,
    input  logic          RegWriteE,
    input  logic          RegWriteM,
    input  logic          RegWriteW,
    input  logic          ResultSrcE0,
    input  logic          PCJmpE,
    input  logic          FPUStartE,
    input  logic          FPUDoneE,
    output logic [1:0]    ForwardAE,
    output logic [1:0]    ForwardBE,
    output logic          StallF,
    output logic          StallD,
    output logic          StallE,
    output logic          FlushD,
    output logic          FlushE,
    output logic          FlushM,
    output logic          FPUBusy,
    output logic          FPUTimeout
);

    localparam int            CW       = $clog2(MAXLAT + 1);
    localparam logic [CW-1:0] CNT_MAX  = CW'(MAXLAT);
    localparam logic [CW-1:0] CNT_LAST = CW'(MAXLAT - 1);

    fsm_state_e    state_q;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          timeout_q;

    fwd_sel_e      fwd_a;
    fwd_sel_e      fwd_b;

    logic          rde_live;
    logic          lw_stall;
    logic          mc_stall;
    logic          timeout_hit;

    // ------------------------------------------------------------------
    // Forwarding, one selector per E operand
    // ------------------------------------------------------------------
    fwd_sel #(
        .AW       (AW),
        .ZERO_REG (ZERO_REG)
    ) u_fwd_a (
        .rs_i         (Rs1E),
        .rd_m_i       (RdM),
        .regwrite_m_i (RegWriteM),
        .rd_w_i       (RdW),
        .regwrite_w_i (RegWriteW),
        .sel_o        (fwd_a)
    );

    fwd_sel #(
        .AW       (AW),
        .ZERO_REG (ZERO_REG)
    ) u_fwd_b (
        .rs_i         (Rs2E),
        .rd_m_i       (RdM),
        .regwrite_m_i (RegWriteM),
        .rd_w_i       (RdW),
        .regwrite_w_i (RegWriteW),
        .sel_o        (fwd_b)
    );

    assign ForwardAE = fwd_a;
    assign ForwardBE = fwd_b;

    // ------------------------------------------------------------------
    // Stall / flush terms
    // ------------------------------------------------------------------
    assign rde_live = (ZERO_REG == 0) || (RdE != '0);
    assign lw_stall = ResultSrcE0 && RegWriteE && rde_live &&
                      ((RdE == Rs1D) || (RdE == Rs2D));

    // The multi-cycle stall is a function of FSM state, so it is forced low
    // while reset is asserted even if the state register still reads BUSY.
    assign mc_stall = !reset &&
                      (((state_q == IDLE) && FPUStartE && !FPUDoneE) ||
                       ((state_q == BUSY) && !FPUDoneE));

    assign StallF = lw_stall | mc_stall;
    assign StallD = lw_stall | mc_stall;
    assign StallE = mc_stall;
    assign FlushM = mc_stall;
    // A held E stage must not be flushed; a pending jump simply waits for
    // the release cycle, when PCJmpE is still presented by the held E op.
    assign FlushE = (lw_stall | PCJmpE) & ~mc_stall;
    assign FlushD = PCJmpE & ~mc_stall;

    // ------------------------------------------------------------------
    // Multi-cycle FSM with saturating latency counter
    // ------------------------------------------------------------------
    assign cnt_d       = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CW'(1);
    // Fires on the BUSY cycle whose increment brings the count to MAXLAT,
    // so the FSM is back in IDLE after exactly MAXLAT busy cycles.
    assign timeout_hit = (state_q == BUSY) && !FPUDoneE && (cnt_q >= CNT_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (FPUStartE && !FPUDoneE) begin
                        state_q <= BUSY;
                        cnt_q   <= '0;
                    end
                end
                BUSY: begin
                    if (FPUDoneE) begin
                        state_q <= IDLE;
                    end else begin
                        cnt_q <= cnt_d;
                        if (timeout_hit) begin
                            state_q   <= IDLE;
                            timeout_q <= 1'b1;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign FPUBusy    = (state_q == BUSY);
    assign FPUTimeout = timeout_q;

endmodule : hazard_scoreboard
`default_nettype wire
